// File: rtl/mdu_ctrl.sv
// Multiply/divide controller: owns HI/LO, runs a fixed-length busy period per MULT/DIV,
// and services MTHI/MTLO writes while idle.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic        wr_hi,
  input  logic        wr_lo,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use_D,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW = ($clog2(MaxCycles + 1) > 4) ? $clog2(MaxCycles + 1) : 4;
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e          state;
  logic [CntW-1:0] cnt;
  logic [31:0]     p_hi, p_lo;
  logic            p_wr;

  logic signed [63:0] prod_s;
  logic        [63:0] prod_u;
  logic               div_zero, div_signed;
  logic        [31:0] divisor, abs_a, abs_b, uq, ur, quo, rem;
  logic        [63:0] res;
  logic               res_wr;
  logic [CntW-1:0]    res_cnt;

  assign prod_s = $signed({{32{rs_val[31]}}, rs_val}) * $signed({{32{rt_val[31]}}, rt_val});
  assign prod_u = {32'b0, rs_val} * {32'b0, rt_val};

  // Divide on magnitudes so the signed case truncates toward zero and overflow wraps cleanly.
  assign div_zero   = (rt_val == 32'd0);
  assign div_signed = (md_op == 2'd2);
  assign divisor    = div_zero ? 32'd1 : rt_val;
  assign abs_a      = (div_signed && rs_val[31]) ? -rs_val : rs_val;
  assign abs_b      = (div_signed && divisor[31]) ? -divisor : divisor;
  assign uq         = abs_a / abs_b;
  assign ur         = abs_a % abs_b;
  assign quo        = (div_signed && (rs_val[31] ^ rt_val[31])) ? -uq : uq;
  assign rem        = (div_signed && rs_val[31]) ? -ur : ur;

  always_comb begin
    res     = 64'd0;
    res_wr  = 1'b0;
    res_cnt = MultLoad;
    unique case (md_op)
      2'd0: begin
        res    = prod_s;
        res_wr = 1'b1;
      end
      2'd1: begin
        res    = prod_u;
        res_wr = 1'b1;
      end
      default: begin
        res     = {rem, quo};
        res_wr  = ~div_zero;
        res_cnt = DivLoad;
      end
    endcase
  end

  assign stall_md = md_use_D & (start | busy);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= StIdle;
      cnt   <= '0;
      p_hi  <= 32'd0;
      p_lo  <= 32'd0;
      p_wr  <= 1'b0;
      busy  <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
    end else begin
      unique case (state)
        StIdle: begin
          if (start) begin
            {p_hi, p_lo} <= res;
            p_wr         <= res_wr;
            cnt          <= res_cnt;
            state        <= StBusy;
            busy         <= 1'b1;
          end else begin
            if (wr_hi) hi <= rs_val;
            if (wr_lo) lo <= rs_val;
          end
        end
        StBusy: begin
          cnt <= cnt - 1'b1;
          if (cnt == CntW'(1)) begin
            if (p_wr) begin
              hi <= p_hi;
              lo <= p_lo;
            end
            state <= StIdle;
            busy  <= 1'b0;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed cases plus randomized operations compared
// against an arithmetic reference model of HI/LO.
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  md_op;
  logic        wr_hi, wr_lo;
  logic [31:0] rs_val, rt_val;
  logic        md_use_D;
  logic        busy, stall_md;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  always #5 clk = ~clk;

  mdu_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .md_op    (md_op),
    .wr_hi    (wr_hi),
    .wr_lo    (wr_lo),
    .rs_val   (rs_val),
    .rt_val   (rt_val),
    .md_use_D (md_use_D),
    .busy     (busy),
    .stall_md (stall_md),
    .hi       (hi),
    .lo       (lo)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definitions.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sb, sq, sr;
    logic [63:0] p;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'd0: begin
        p = 64'(sa * sb);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      2'd1: begin
        p = {32'b0, a} * {32'b0, b};
        m_hi = p[63:32];
        m_lo = p[31:0];
      end
      2'd2: if (b != 0) begin
        sq = sa / sb;
        sr = sa % sb;
        m_lo = sq[31:0];
        m_hi = sr[31:0];
      end
      default: if (b != 0) begin
        m_lo = a / b;
        m_hi = a % b;
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic use_d, input logic lo_with_start, input logic noise);
    int n;
    n = (op < 2) ? 5 : 10;
    @(negedge clk);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b;
    md_use_D = use_d; wr_lo = lo_with_start;
    #1 chk("stall_issue", {31'b0, stall_md}, {31'b0, use_d});
    model(op, a, b);
    @(negedge clk);
    start = 1'b0; wr_lo = 1'b0;
    for (int i = 0; i < n; i++) begin
      chk("busy_on", {31'b0, busy}, 32'd1);
      chk("stall_busy", {31'b0, stall_md}, {31'b0, use_d});
      chk("hi_hold", hi, hi_before(i));
      if (noise) begin
        start = 1'($urandom); wr_hi = 1'($urandom); wr_lo = 1'($urandom);
        md_op = 2'($urandom); rs_val = $urandom; rt_val = $urandom;
      end
      @(negedge clk);
    end
    start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    #1;
    chk("busy_off", {31'b0, busy}, 32'd0);
    chk("stall_after", {31'b0, stall_md}, 32'd0);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    md_use_D = 1'b0;
  endtask

  // HI must not change during the busy period; capture it on the first busy cycle.
  logic [31:0] hold_hi;
  function automatic logic [31:0] hi_before(input int i);
    if (i == 0) hold_hi = hi;
    return hold_hi;
  endfunction

  task automatic idle_write(input logic to_hi, input logic [31:0] v);
    @(negedge clk);
    wr_hi = to_hi; wr_lo = ~to_hi; rs_val = v;
    @(negedge clk);
    wr_hi = 1'b0; wr_lo = 1'b0;
    if (to_hi) m_hi = v; else m_lo = v;
    chk("mt_hi", hi, m_hi);
    chk("mt_lo", lo, m_lo);
    chk("mt_busy", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; md_op = 2'd0; wr_hi = 1'b0; wr_lo = 1'b0;
    rs_val = 32'd0; rt_val = 32'd0; md_use_D = 1'b1;
    #1;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_stall", {31'b0, stall_md}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0; md_use_D = 1'b0;

    run_op(2'd0, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b0, 1'b0);
    chk("mult_neg_hi", hi, 32'hFFFF_FFFF);
    chk("mult_neg_lo", lo, 32'hFFFF_FFFA);
    run_op(2'd3, 32'd100, 32'd7, 1'b0, 1'b0, 1'b0);
    chk("divu_q", lo, 32'd14);
    chk("divu_r", hi, 32'd2);
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
    chk("div_q", lo, 32'hFFFF_FFFD);
    chk("div_r", hi, 32'hFFFF_FFFF);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    chk("div_ovf_q", lo, 32'h8000_0000);
    chk("div_ovf_r", hi, 32'd0);

    idle_write(1'b1, 32'h1234_5678);
    run_op(2'd3, 32'd55, 32'd0, 1'b0, 1'b0, 1'b0);
    chk("div0_hi", hi, 32'h1234_5678);
    run_op(2'd2, 32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0, 1'b0);

    run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    // start wins over a same-cycle MTLO; writes during busy are dropped
    run_op(2'd0, 32'd7, 32'hFFFF_FFFD, 1'b1, 1'b1, 1'b1);
    chk("prio_lo", lo, 32'hFFFF_FFEB);

    // reset in the third busy cycle of a DIV
    @(negedge clk);
    start = 1'b1; md_op = 2'd2; rs_val = 32'd1000; rt_val = 32'd3;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("abort_busy", {31'b0, busy}, 32'd0);
    chk("abort_hi", hi, m_hi);
    chk("abort_lo", lo, m_lo);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    chk("abort_late_hi", hi, m_hi);
    chk("abort_late_lo", lo, m_lo);
    chk("abort_late_busy", {31'b0, busy}, 32'd0);

    for (int k = 0; k < 30; k++) begin
      logic [1:0]  op;
      logic [31:0] a, b;
      op = 2'($urandom);
      a  = $urandom;
      b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 3) == 0) idle_write(1'($urandom), $urandom);
      run_op(op, a, b, 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
